pc_gen: RTL and testbench

Parametrised program-counter generator for the RISC-V fetch stage, successor to the single-branch program counter. Produces the fetch address with a valid/ready handshake to instruction memory and prioritised redirects: trap, trap return, call/return through a small return-address stack, and taken branch/jump. Sits between the core's control/execute redirect logic and the instruction-memory port.

---
 rtl/pc_gen.sv | 179 +++++++++++++++++
 tb/tb_pc_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program-counter generator for the RISC-V fetch stage.
//
// Presents a fetch address to instruction memory with a valid/ready handshake
// and applies prioritised redirects: trap, trap return (mret), return through a
// small circular return-address stack (RAS), and taken branch/jump (optionally
// a call, which pushes its return address). Every output is driven from a
// register, so there is no combinational path from inputs to outputs.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   pc_ready       in   instruction memory accepts the current pc
//   branch_en      in   taken branch/jump redirect
//   branch_target  in   target for branch/call; fallback target for an
//                       empty-RAS return
//   call_en        in   call qualifier, only meaningful with branch_en
//   call_pc        in   PC of the call instruction
//   ret_en         in   return, pops the RAS
//   trap_en        in   exception/interrupt taken
//   trap_pc        in   faulting PC, captured into epc
//   mret_en        in   return from trap
//   pc             out  current fetch address
//   pc_valid       out  pc is a valid fetch request
//   redirect       out  one-cycle pulse: pc was loaded by a redirect
//   epc            out  saved exception PC
//   ras_empty      out  RAS holds no entries
//   ras_full       out  RAS holds RAS_DEPTH entries
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned        XLEN        = 32,
    parameter logic [XLEN-1:0]    RESET_PC    = 32'h0000_0000,
    parameter logic [XLEN-1:0]    TRAP_VECTOR = 32'h0000_0100,
    parameter int unsigned        PC_STEP     = 4,
    parameter int unsigned        RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_ready,
    input  logic            branch_en,
    input  logic [XLEN-1:0] branch_target,
    input  logic            call_en,
    input  logic [XLEN-1:0] call_pc,
    input  logic            ret_en,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_en,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            redirect,
    output logic [XLEN-1:0] epc,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [XLEN-1:0]  STEP       = XLEN'(PC_STEP);
    // Clears the low log2(PC_STEP) bits of every redirect target.
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~(STEP - XLEN'(1));
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pc_valid_q;
    logic             redirect_q, redirect_d;
    logic [XLEN-1:0]  epc_q, epc_d;

    // ras_ptr_q indexes the next free slot; the top entry sits just below it.
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];

    logic             ras_push, ras_pop;
    logic [XLEN-1:0]  ras_top;
    logic [XLEN-1:0]  ret_addr;

    assign ras_top  = ras_mem_q[ras_ptr_q - PTR_W'(1)];
    assign ret_addr = call_pc + STEP;

    // ------------------------------------------------------------------
    // Next-PC selection, highest priority first.
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;

        if (trap_en) begin
            pc_d       = TRAP_VECTOR & ALIGN_MASK;
            epc_d      = trap_pc;
            redirect_d = 1'b1;
        end else if (mret_en) begin
            pc_d       = epc_q & ALIGN_MASK;
            redirect_d = 1'b1;
        end else if (ret_en) begin
            // An empty stack falls back to the predicted target and pops nothing.
            if (ras_cnt_q != '0) begin
                pc_d    = ras_top & ALIGN_MASK;
                ras_pop = 1'b1;
            end else begin
                pc_d    = branch_target & ALIGN_MASK;
            end
            redirect_d = 1'b1;
        end else if (branch_en) begin
            pc_d       = branch_target & ALIGN_MASK;
            ras_push   = call_en;
            redirect_d = 1'b1;
        end else if (pc_valid_q && pc_ready) begin
            pc_d = pc_q + STEP;
        end
    end

    // Stack pointer/count. A push onto a full stack overwrites the oldest
    // slot (which is exactly the one ras_ptr_q points at) and keeps the count.
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_push) begin
            ras_ptr_d = ras_ptr_q + PTR_W'(1);
            if (ras_cnt_q != CNT_FULL) begin
                ras_cnt_d = ras_cnt_q + CNT_W'(1);
            end
        end else if (ras_pop) begin
            ras_ptr_d = ras_ptr_q - PTR_W'(1);
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            redirect_q <= 1'b0;
            epc_q      <= '0;
            ras_ptr_q  <= '0;
            ras_cnt_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
            redirect_q <= redirect_d;
            epc_q      <= epc_d;
            ras_ptr_q  <= ras_ptr_d;
            ras_cnt_q  <= ras_cnt_d;
        end
    end

    // NOTE: the stack storage is deliberately not reset; the count guards
    // every read, so stale contents are never observed and the array can
    // map onto plain flops or a register file without reset wiring.
    always_ff @(posedge clk) begin
        if (!rst && ras_push) begin
            ras_mem_q[ras_ptr_q] <= ret_addr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign redirect  = redirect_q;
    assign epc       = epc_q;
    assign ras_empty = (ras_cnt_q == '0);
    assign ras_full  = (ras_cnt_q == CNT_FULL);

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- directed testbench for pc_gen.
//
// u_dut  : default parameters (RESET_PC=0, PC_STEP=4, RAS_DEPTH=4).
// u_wrap : RESET_PC=32'hFFFF_FFF8, exercises modulo wrap and target alignment.
// Inputs change #1 after a rising edge; outputs are sampled at the same point,
// i.e. after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;

    logic        pc_ready, branch_en, call_en, ret_en, trap_en, mret_en;
    logic [31:0] branch_target, call_pc, trap_pc;
    logic [31:0] pc, epc;
    logic        pc_valid, redirect, ras_empty, ras_full;

    logic        w_ready, w_branch_en;
    logic [31:0] w_target;
    logic [31:0] w_pc, w_epc;
    logic        w_pc_valid, w_redirect, w_ras_empty, w_ras_full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_gen u_dut (
        .clk           (clk),
        .rst           (rst),
        .pc_ready      (pc_ready),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .call_en       (call_en),
        .call_pc       (call_pc),
        .ret_en        (ret_en),
        .trap_en       (trap_en),
        .trap_pc       (trap_pc),
        .mret_en       (mret_en),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .redirect      (redirect),
        .epc           (epc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    pc_gen #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .pc_ready      (w_ready),
        .branch_en     (w_branch_en),
        .branch_target (w_target),
        .call_en       (1'b0),
        .call_pc       (32'h0),
        .ret_en        (1'b0),
        .trap_en       (1'b0),
        .trap_pc       (32'h0),
        .mret_en       (1'b0),
        .pc            (w_pc),
        .pc_valid      (w_pc_valid),
        .redirect      (w_redirect),
        .epc           (w_epc),
        .ras_empty     (w_ras_empty),
        .ras_full      (w_ras_full)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_ready      = 1'b0;
        branch_en     = 1'b0;
        call_en       = 1'b0;
        ret_en        = 1'b0;
        trap_en       = 1'b0;
        mret_en       = 1'b0;
        branch_target = 32'h0;
        call_pc       = 32'h0;
        trap_pc       = 32'h0;
    endtask

    // One call: branch to 0x800, push call_pc+4.
    task automatic do_call(input logic [31:0] cpc);
        idle_inputs();
        branch_en     = 1'b1;
        call_en       = 1'b1;
        call_pc       = cpc;
        branch_target = 32'h800;
        step();
    endtask

    localparam logic [31:0] CALL_PCS [5] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};
    localparam logic [31:0] RET_EXP  [4] = '{32'h504, 32'h404, 32'h304, 32'h204};

    initial begin
        idle_inputs();
        rst         = 1'b1;
        w_ready     = 1'b0;
        w_branch_en = 1'b0;
        w_target    = 32'h0;

        // ---- Reset ----
        step();
        step();
        check("rst_pc",        pc,        32'h0);
        check("rst_valid",     pc_valid,  1'b0);
        check("rst_redirect",  redirect,  1'b0);
        check("rst_epc",       epc,       32'h0);
        check("rst_ras_empty", ras_empty, 1'b1);
        check("rst_ras_full",  ras_full,  1'b0);
        check("rst_wrap_pc",   w_pc,      32'hFFFF_FFF8);

        // ---- Reset release and sequential run ----
        rst      = 1'b0;
        pc_ready = 1'b1;
        step();
        check("seq0_pc",    pc,       32'h0);
        check("seq0_valid", pc_valid, 1'b1);
        step();
        check("seq1_pc",    pc,       32'h4);
        step();
        check("seq2_pc",    pc,       32'h8);

        // ---- Stall for three cycles ----
        pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_pc", i), pc, 32'h8);
        end

        // ---- Branch while not ready ----
        branch_en     = 1'b1;
        branch_target = 32'h10;
        step();
        check("br_pc",       pc,       32'h10);
        check("br_redirect", redirect, 1'b1);
        idle_inputs();
        pc_ready = 1'b1;
        step();
        check("br_next_pc",  pc,       32'h14);
        check("br_redir_lo", redirect, 1'b0);

        // ---- Call without branch is ignored ----
        idle_inputs();
        call_en = 1'b1;
        call_pc = 32'h900;
        step();
        check("lone_call_empty", ras_empty, 1'b1);
        check("lone_call_pc",    pc,        32'h14);

        // ---- Five calls into a four-deep RAS ----
        for (int i = 0; i < 5; i++) begin
            do_call(CALL_PCS[i]);
            check($sformatf("call%0d_pc", i),   pc,       32'h800);
            check($sformatf("call%0d_full", i), ras_full, (i >= 3) ? 1'b1 : 1'b0);
        end
        check("calls_nonempty", ras_empty, 1'b0);

        // ---- Five returns: four from the stack, one fallback ----
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            ret_en        = 1'b1;
            branch_target = 32'h40;
            step();
            check($sformatf("ret%0d_pc", i),    pc,       RET_EXP[i]);
            check($sformatf("ret%0d_redir", i), redirect, 1'b1);
            check($sformatf("ret%0d_full", i),  ras_full, 1'b0);
        end
        check("ret_all_empty", ras_empty, 1'b1);
        idle_inputs();
        ret_en        = 1'b1;
        branch_target = 32'h42;
        step();
        check("ret_fallback_pc",    pc,        32'h40);
        check("ret_fallback_redir", redirect,  1'b1);
        check("ret_fallback_empty", ras_empty, 1'b1);

        // ---- Trap wins over branch and ret; RAS unchanged ----
        do_call(32'h600);
        idle_inputs();
        branch_en     = 1'b1;
        branch_target = 32'h20;
        step();
        check("pre_trap_pc", pc, 32'h20);
        idle_inputs();
        trap_en       = 1'b1;
        trap_pc       = 32'h1C;
        branch_en     = 1'b1;
        branch_target = 32'h80;
        ret_en        = 1'b1;
        step();
        check("trap_pc",       pc,        32'h100);
        check("trap_epc",      epc,       32'h1C);
        check("trap_redirect", redirect,  1'b1);
        check("trap_ras_kept", ras_empty, 1'b0);
        idle_inputs();
        pc_ready = 1'b1;
        step();
        check("vec_seq_pc", pc, 32'h104);
        idle_inputs();
        mret_en = 1'b1;
        ret_en  = 1'b1;
        step();
        check("mret_pc",       pc,        32'h1C);
        check("mret_ras_kept", ras_empty, 1'b0);
        idle_inputs();
        ret_en = 1'b1;
        step();
        check("post_trap_ret_pc", pc,        32'h604);
        check("post_trap_empty",  ras_empty, 1'b1);

        // ---- Wrap and alignment on the second instance ----
        idle_inputs();
        check("wrap_hold_pc", w_pc, 32'hFFFF_FFF8);
        w_ready = 1'b1;
        step();
        check("wrap0_pc", w_pc, 32'hFFFF_FFFC);
        step();
        check("wrap1_pc", w_pc, 32'h0);
        w_ready     = 1'b0;
        w_branch_en = 1'b1;
        w_target    = 32'h13;
        step();
        check("align_pc",    w_pc,       32'h10);
        check("align_redir", w_redirect, 1'b1);
        w_branch_en = 1'b0;

        // ---- Reset in the same cycle as a call ----
        do_call(32'h700);
        check("pre_rst_empty", ras_empty, 1'b0);
        idle_inputs();
        branch_en     = 1'b1;
        call_en       = 1'b1;
        call_pc       = 32'h700;
        branch_target = 32'h900;
        rst           = 1'b1;
        step();
        check("mid_rst_pc",       pc,        32'h0);
        check("mid_rst_empty",    ras_empty, 1'b1);
        check("mid_rst_redirect", redirect,  1'b0);
        check("mid_rst_valid",    pc_valid,  1'b0);
        check("mid_rst_epc",      epc,       32'h0);
        rst = 1'b0;
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
